// File: rtl/axi4lite_reg4_slave.sv
// Four 32-bit AXI4-Lite registers; write lands on the edge where both AW and W are present, B/R valid the cycle after.
// Backpressure: each channel holds valid and data stable until its ready; a new AW/W/AR is refused while a response is pending.
module axi4lite_reg4_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
    output logic [3:0]                        wr_pulse_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e             w_state_q, w_state_d;
    r_state_e             r_state_q, r_state_d;
    logic                 rdy_en_q;
    logic                 aw_held_q, aw_held_d;
    logic [1:0]           aw_idx_q, aw_idx_d;
    logic                 w_held_q, w_held_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [SW-1:0]        wstrb_q, wstrb_d;
    logic [3:0][DW-1:0]   regs_q, regs_d;
    logic [3:0]           wr_pulse_q, wr_pulse_d;
    logic [DW-1:0]        rdata_q, rdata_d;

    logic                 aw_hs, w_hs, ar_hs, wr_fire;
    logic [1:0]           wr_idx;
    logic [DW-1:0]        wr_data;
    logic [SW-1:0]        wr_strb;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

    // rdy_en_q keeps all readys low until the first clock edge out of reset.
    assign s00_axi_awready = rdy_en_q && !aw_held_q && (w_state_q == W_IDLE);
    assign s00_axi_wready  = rdy_en_q && !w_held_q  && (w_state_q == W_IDLE);
    assign s00_axi_arready = rdy_en_q && (r_state_q == R_IDLE);
    assign s00_axi_bvalid  = (w_state_q == W_RESP);
    assign s00_axi_rvalid  = (r_state_q == R_DATA);
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rdata   = rdata_q;
    assign reg0_o          = regs_q[0];
    assign reg1_o          = regs_q[1];
    assign reg2_o          = regs_q[2];
    assign reg3_o          = regs_q[3];
    assign wr_pulse_o      = wr_pulse_q;

    assign aw_hs   = s00_axi_awvalid && s00_axi_awready;
    assign w_hs    = s00_axi_wvalid  && s00_axi_wready;
    assign ar_hs   = s00_axi_arvalid && s00_axi_arready;
    assign wr_fire = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_idx  = aw_held_q ? aw_idx_q : s00_axi_awaddr[3:2];
    assign wr_data = w_held_q  ? wdata_q  : s00_axi_wdata;
    assign wr_strb = w_held_q  ? wstrb_q  : s00_axi_wstrb;

    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s00_axi_awaddr[3:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s00_axi_wdata;
            wstrb_d  = s00_axi_wstrb;
        end
        case (w_state_q)
            W_IDLE: begin
                if (wr_fire) begin
                    w_state_d          = W_RESP;
                    wr_pulse_d[wr_idx] = 1'b1;
                    for (int k = 0; k < SW; k++) begin
                        if (wr_strb[k]) begin
                            regs_d[wr_idx][8*k +: 8] = wr_data[8*k +: 8];
                        end
                    end
                end
            end
            W_RESP: begin
                // Both holding flags stay set through the response so readys stay low.
                if (s00_axi_bready) begin
                    w_state_d = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                // regs_q is sampled before any same-edge write, so reads see the old value.
                if (ar_hs) begin
                    rdata_d   = regs_q[s00_axi_araddr[3:2]];
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            rdy_en_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            regs_q     <= '0;
            wr_pulse_q <= '0;
            rdata_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            rdy_en_q   <= 1'b1;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_reg4_slave.sv
// Randomized AXI4-Lite traffic against a register-array reference model, plus directed corner cases.
module tb_axi4lite_reg4_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb, wr_pulse;
    logic [1:0]  bresp, rresp;
    logic [31:0] reg0, reg1, reg2, reg3;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [4];

    always #5 clk = ~clk;

    axi4lite_reg4_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3), .wr_pulse_o(wr_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_out(input int i);
        case (i)
            0: return reg0;
            1: return reg1;
            2: return reg2;
            default: return reg3;
        endcase
    endfunction

    task automatic check_regs();
        for (int i = 0; i < 4; i++) chk($sformatf("reg%0d_o", i), reg_out(i), model[i]);
    endtask

    // Caller is #1 after a rising edge. Delays count cycles before each valid is raised.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        int idx = int'(a[3:2]);
        while (!(aw_done && w_done)) begin
            awaddr  = a;
            wdata   = d;
            wstrb   = s;
            awvalid = (cyc >= aw_dly) && !aw_done;
            wvalid  = (cyc >= w_dly) && !w_done;
            @(negedge clk);
            chk("bvalid_before_write", {31'd0, bvalid}, 32'd0);
            if (w_done && !aw_done) begin
                chk("awready_w_held", {31'd0, awready}, 32'd1);
                chk("wready_w_held", {31'd0, wready}, 32'd0);
            end
            if (aw_done && !w_done) chk("awready_aw_held", {31'd0, awready}, 32'd0);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            cyc++;
            if (cyc > 40) begin
                chk("write_handshake_timeout", 32'd0, 32'd1);
                break;
            end
        end
        awvalid = 0;
        wvalid  = 0;
        for (int k = 0; k < 4; k++) if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
        for (int k = 0; k <= b_dly; k++) begin
            bready = (k == b_dly);
            @(negedge clk);
            chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
            chk("bresp", {30'd0, bresp}, 32'd0);
            chk("wr_pulse", {28'd0, wr_pulse}, (k == 0) ? (32'd1 << idx) : 32'd0);
            chk("awready_in_resp", {31'd0, awready}, 32'd0);
            chk("wready_in_resp", {31'd0, wready}, 32'd0);
            if (k == 0) check_regs();
            @(posedge clk); #1;
        end
        bready = 0;
        @(negedge clk);
        chk("bvalid_after_b", {31'd0, bvalid}, 32'd0);
        chk("awready_after_b", {31'd0, awready}, 32'd1);
        chk("wready_after_b", {31'd0, wready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] a, input int ar_dly, input int r_dly);
        bit hs = 0;
        int cyc = 0;
        logic [31:0] exp = 32'd0;
        while (!hs) begin
            araddr  = a;
            arvalid = (cyc >= ar_dly);
            @(negedge clk);
            if (arvalid && arready) begin
                hs  = 1;
                exp = model[int'(a[3:2])];
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 40) begin
                chk("read_handshake_timeout", 32'd0, 32'd1);
                break;
            end
        end
        arvalid = 0;
        for (int k = 0; k <= r_dly; k++) begin
            rready = (k == r_dly);
            @(negedge clk);
            chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
            chk("rdata", rdata, exp);
            chk("rresp", {30'd0, rresp}, 32'd0);
            chk("arready_in_resp", {31'd0, arready}, 32'd0);
            @(posedge clk); #1;
        end
        rready = 0;
        @(negedge clk);
        chk("rvalid_after_r", {31'd0, rvalid}, 32'd0);
        chk("arready_after_r", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_awready"}, {31'd0, awready}, 32'd0);
        chk({tag, "_wready"}, {31'd0, wready}, 32'd0);
        chk({tag, "_arready"}, {31'd0, arready}, 32'd0);
        chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_wr_pulse"}, {28'd0, wr_pulse}, 32'd0);
        check_regs();
    endtask

    initial begin
        rst_n = 0; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = 0; wstrb = 0;
        for (int i = 0; i < 4; i++) model[i] = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("awready_before_first_edge", {31'd0, awready}, 32'd0);
        chk("arready_before_first_edge", {31'd0, arready}, 32'd0);
        @(posedge clk); #1;

        // Basic write and readback of all four registers
        for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0, 0);

        // Partial byte strobes
        axi_write(4'h4, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        axi_write(4'h4, 32'h11223344, 4'b0101, 0, 0, 0);
        chk("strobe_merge_model", model[1], 32'hAA22CC44);
        axi_read(4'h4, 0, 0);

        // W leads AW by three cycles
        axi_write(4'h8, 32'hCAFE0002, 4'hF, 3, 0, 0);
        // Responses stalled for four cycles
        axi_write(4'hC, 32'h00000004, 4'hF, 0, 0, 4);
        axi_read(4'h8, 0, 4);

        // Same-edge write and read of register 3 returns the old value
        fork
            axi_write(4'hC, 32'h00000005, 4'hF, 0, 0, 0);
            axi_read(4'hC, 0, 0);
        join
        chk("reg3_after_concurrent", reg3, 32'h00000005);

        // Randomized concurrent traffic
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  wa = 4'($urandom_range(0, 15));
            logic [3:0]  ra = 4'($urandom_range(0, 15));
            logic [31:0] wd = $urandom;
            logic [3:0]  ws = 4'($urandom_range(0, 15));
            int mode = $urandom_range(0, 2);
            if (mode == 0) axi_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else if (mode == 1) axi_read(ra, $urandom_range(0, 3), $urandom_range(0, 3));
            else fork
                axi_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                axi_read(ra, $urandom_range(0, 3), $urandom_range(0, 3));
            join
        end

        // Reset with AW held and W pending
        awaddr = 4'h0; awvalid = 1;
        @(negedge clk);
        chk("awready_pre_reset", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 0; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        #2;
        rst_n = 0;
        wvalid = 0;
        for (int i = 0; i < 4; i++) model[i] = 32'd0;
        #1;
        check_reset_state("midreset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("bvalid_after_midreset", {31'd0, bvalid}, 32'd0);
        chk("wr_pulse_after_midreset", {28'd0, wr_pulse}, 32'd0);
        @(posedge clk); #1;
        axi_write(4'h0, 32'h12345678, 4'hF, 0, 1, 0);
        axi_read(4'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
